// File: rtl/cdr_pkg.sv
// ---------------------------------------------------------------------------
// cdr_pkg
// Shared types and constants for the XAUI receive-lane CDR loop filter.
//   PI_BITS  : width of the phase-interpolator code (quadrant + fine step)
//   STEP_ACQ : code step applied per decision while acquiring
//   STEP_TRK : code step applied per decision while tracking
//   cdr_state_e : loop filter states
//   cdr_dir_e   : per-window decision
//   pi_step()   : modulo-2^PI_BITS code update
// ---------------------------------------------------------------------------
package cdr_pkg;

  localparam int PI_BITS = 6;

  localparam logic [PI_BITS-1:0] STEP_ACQ = 6'd2;
  localparam logic [PI_BITS-1:0] STEP_TRK = 6'd1;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } cdr_state_e;

  typedef enum logic [1:0] {
    HOLD_D = 2'd0,
    UP     = 2'd1,
    DN     = 2'd2
  } cdr_dir_e;

  // Quadrant wrap is legal, so the code simply rolls over in both directions.
  function automatic logic [PI_BITS-1:0] pi_step(
    input logic [PI_BITS-1:0] code,
    input cdr_dir_e           dir,
    input logic [PI_BITS-1:0] step
  );
    logic [PI_BITS-1:0] res;
    case (dir)
      UP:      res = code + step;
      DN:      res = code - step;
      default: res = code;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cdr_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// cdr_phase_ctrl_if
// Bundles the phase-detector votes, freeze control and PI code outputs.
//   pd_valid, early, late : bang-bang phase-detector vote for this cycle
//   freeze                : hold vs/lock and discard votes while high
//   vs[5:0]               : PI code (vs[5:4] quadrant, vs[3:0] fine step)
//   lock                  : loop locked
//   ovr_en, ovr_code      : code override (present only with CDR_OVERRIDE_EN)
// Modports: master = vote source / consumer of vs, slave = cdr_phase_ctrl.
// ---------------------------------------------------------------------------
interface cdr_phase_ctrl_if;
  import cdr_pkg::*;

  logic               pd_valid;
  logic               early;
  logic               late;
  logic               freeze;
  logic [PI_BITS-1:0] vs;
  logic               lock;
`ifdef CDR_OVERRIDE_EN
  logic               ovr_en;
  logic [PI_BITS-1:0] ovr_code;
`endif

  modport master (
`ifdef CDR_OVERRIDE_EN
    output ovr_en,
    output ovr_code,
`endif
    output pd_valid,
    output early,
    output late,
    output freeze,
    input  vs,
    input  lock
  );

  modport slave (
`ifdef CDR_OVERRIDE_EN
    input  ovr_en,
    input  ovr_code,
`endif
    input  pd_valid,
    input  early,
    input  late,
    input  freeze,
    output vs,
    output lock
  );

endinterface

// File: rtl/cdr_vote_window.sv
// ---------------------------------------------------------------------------
// cdr_vote_window
// Accumulates bang-bang votes over VOTE_LEN valid samples and reports the
// window decision.
//   clk, rst_n : lane clock, async active-low reset
//   i_valid    : vote present this cycle
//   i_early    : +1 vote (when not also late)
//   i_late     : -1 vote (when not also early)
//   i_clear    : discard the current window (dominates everything)
//   o_close    : high for the one cycle in which the window is full
//   o_dir      : decision of the full window (valid with o_close)
// The window is held full for one cycle so the consumer can act on the next
// edge; a sample arriving in that cycle opens the next window, so
// back-to-back votes are never lost.
// ---------------------------------------------------------------------------
module cdr_vote_window
  import cdr_pkg::*;
#(
  parameter int VOTE_LEN = 8,
  parameter int THRESH   = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_valid,
  input  logic     i_early,
  input  logic     i_late,
  input  logic     i_clear,
  output logic     o_close,
  output cdr_dir_e o_dir
);

  localparam int CW = $clog2(VOTE_LEN) + 1;
  localparam int SW = $clog2(VOTE_LEN) + 2;

  localparam logic [CW-1:0]        FULL  = CW'(VOTE_LEN);
  localparam logic signed [SW-1:0] THR_P = SW'(THRESH);
  localparam logic signed [SW-1:0] THR_N = -THR_P;

  logic [CW-1:0]        r_cnt;
  logic signed [SW-1:0] r_sum;
  logic [CW-1:0]        w_cnt_nxt;
  logic signed [SW-1:0] w_sum_nxt;
  logic signed [SW-1:0] w_vote;
  logic                 w_full;

  assign w_full  = (r_cnt == FULL);
  assign o_close = w_full;

  // Vote decode: contradictory or empty votes still occupy a window slot.
  always_comb begin
    w_vote = {SW{1'b0}};
    case ({i_early, i_late})
      2'b10:   w_vote = SW'(1);
      2'b01:   w_vote = {SW{1'b1}};
      default: w_vote = {SW{1'b0}};
    endcase
  end

  // Window decision from the accumulated sum.
  always_comb begin
    o_dir = HOLD_D;
    if (r_sum >= THR_P) begin
      o_dir = UP;
    end else if (r_sum <= THR_N) begin
      o_dir = DN;
    end else begin
      o_dir = HOLD_D;
    end
  end

  // Next sample count / sum.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sum_nxt = r_sum;
    if (i_clear) begin
      w_cnt_nxt = {CW{1'b0}};
      w_sum_nxt = {SW{1'b0}};
    end else if (w_full) begin
      if (i_valid) begin
        w_cnt_nxt = CW'(1);
        w_sum_nxt = w_vote;
      end else begin
        w_cnt_nxt = {CW{1'b0}};
        w_sum_nxt = {SW{1'b0}};
      end
    end else if (i_valid) begin
      w_cnt_nxt = r_cnt + CW'(1);
      w_sum_nxt = r_sum + w_vote;
    end else begin
      w_cnt_nxt = r_cnt;
      w_sum_nxt = r_sum;
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
      r_sum <= {SW{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sum <= w_sum_nxt;
    end
  end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// ---------------------------------------------------------------------------
// cdr_phase_ctrl
// Digital CDR loop filter driving the 4-quadrant phase interpolator code.
//   clk    : lane digital clock
//   rst_n  : asynchronous active-low reset
//   bus    : cdr_phase_ctrl_if.slave (pd_valid, early, late, freeze in;
//            vs[5:0], lock out; ovr_en/ovr_code in with CDR_OVERRIDE_EN)
// Optional feature macro: CDR_OVERRIDE_EN (adds the code override inputs).
// ACQ steps by 2 codes until LOCK_CNT quiet windows, TRACK steps by 1 and
// drops lock after UNLOCK_RUN same-direction steps, HOLD freezes the loop.
// ---------------------------------------------------------------------------
module cdr_phase_ctrl
  import cdr_pkg::*;
#(
  parameter int VOTE_LEN   = 8,
  parameter int THRESH     = 3,
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_RUN = 4
) (
  input logic             clk,
  input logic             rst_n,
  cdr_phase_ctrl_if.slave bus
);

  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int RW  = $clog2(UNLOCK_RUN + 1);

  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CNT - 1);
  localparam logic [RW-1:0]  RUN_TRIP  = RW'(UNLOCK_RUN);

  cdr_state_e         r_state,    w_state_nxt;
  cdr_state_e         r_saved,    w_saved_nxt;
  cdr_dir_e           r_last_dir, w_last_dir_nxt;
  logic [PI_BITS-1:0] r_vs,       w_vs_nxt;
  logic               r_lock,     w_lock_nxt;
  logic [LCW-1:0]     r_lock_cnt, w_lock_cnt_nxt;
  logic [RW-1:0]      r_run,      w_run_nxt;
  logic [RW-1:0]      w_run_inc;

  logic               w_close;
  cdr_dir_e           w_dir;
  logic               w_clear;
  logic               w_ovr_en;
  logic [PI_BITS-1:0] w_ovr_code;

`ifdef CDR_OVERRIDE_EN
  assign w_ovr_en   = bus.ovr_en;
  assign w_ovr_code = bus.ovr_code;
`else
  assign w_ovr_en   = 1'b0;
  assign w_ovr_code = {PI_BITS{1'b0}};
`endif

  // Freeze or override throws away whatever the window has collected.
  assign w_clear = bus.freeze | w_ovr_en;

  cdr_vote_window #(
    .VOTE_LEN (VOTE_LEN),
    .THRESH   (THRESH)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.pd_valid),
    .i_early (bus.early),
    .i_late  (bus.late),
    .i_clear (w_clear),
    .o_close (w_close),
    .o_dir   (w_dir)
  );

  // Loop FSM next-state, code and counter updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_saved_nxt    = r_saved;
    w_last_dir_nxt = r_last_dir;
    w_vs_nxt       = r_vs;
    w_lock_nxt     = r_lock;
    w_lock_cnt_nxt = r_lock_cnt;
    w_run_nxt      = r_run;
    // A step opposite to the previous one restarts the run at 1.
    w_run_inc      = (w_dir == r_last_dir) ? (r_run + RW'(1)) : RW'(1);

    if (w_ovr_en) begin
      w_state_nxt    = ACQ;
      w_saved_nxt    = ACQ;
      w_last_dir_nxt = HOLD_D;
      w_vs_nxt       = w_ovr_code;
      w_lock_nxt     = 1'b0;
      w_lock_cnt_nxt = {LCW{1'b0}};
      w_run_nxt      = {RW{1'b0}};
    end else if (bus.freeze) begin
      // Remember where to resume only on the way in, not while parked.
      if (r_state != HOLD) begin
        w_saved_nxt = r_state;
        w_state_nxt = HOLD;
      end else begin
        w_saved_nxt = r_saved;
      end
    end else if (r_state == HOLD) begin
      w_state_nxt = r_saved;
    end else if (w_close) begin
      case (r_state)
        ACQ: begin
          if (w_dir == HOLD_D) begin
            if (r_lock_cnt == LOCK_LAST) begin
              w_state_nxt    = TRACK;
              w_lock_nxt     = 1'b1;
              w_lock_cnt_nxt = {LCW{1'b0}};
              w_run_nxt      = {RW{1'b0}};
            end else begin
              w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
            end
          end else begin
            w_vs_nxt       = pi_step(r_vs, w_dir, STEP_ACQ);
            w_lock_cnt_nxt = {LCW{1'b0}};
          end
        end
        TRACK: begin
          if (w_dir == HOLD_D) begin
            w_run_nxt = {RW{1'b0}};
          end else begin
            // The tripping step is still applied at tracking size.
            w_vs_nxt       = pi_step(r_vs, w_dir, STEP_TRK);
            w_last_dir_nxt = w_dir;
            if (w_run_inc == RUN_TRIP) begin
              w_state_nxt    = ACQ;
              w_lock_nxt     = 1'b0;
              w_run_nxt      = {RW{1'b0}};
              w_lock_cnt_nxt = {LCW{1'b0}};
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Loop state, PI code and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACQ;
      r_saved    <= ACQ;
      r_last_dir <= HOLD_D;
      r_vs       <= {PI_BITS{1'b0}};
      r_lock     <= 1'b0;
      r_lock_cnt <= {LCW{1'b0}};
      r_run      <= {RW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_saved    <= w_saved_nxt;
      r_last_dir <= w_last_dir_nxt;
      r_vs       <= w_vs_nxt;
      r_lock     <= w_lock_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_run      <= w_run_nxt;
    end
  end

  assign bus.vs   = r_vs;
  assign bus.lock = r_lock;

endmodule
